// File: rtl/cmult_pkg.sv
// Shared types and helpers for the sequential complex multiplier.
// Build option: define CMULT_SAT_EN to saturate results instead of wrapping.
package cmult_pkg;

  typedef enum logic [2:0] {IDLE, P_AC, P_BD, P_AD, P_BC, DONE} state_t;

  localparam int CM_WIDTH   = 8;
  localparam int CM_ACC_W   = 2*CM_WIDTH + 1;
  // Reduction is done at a fixed maximal width so one function serves any WIDTH <= CM_MAX_W.
  localparam int CM_MAX_W   = 32;
  localparam int CM_MAX_ACC = 2*CM_MAX_W + 1;

  typedef struct packed {
    logic                         ovf;
    logic signed [CM_MAX_ACC-1:0] val;
  } red_t;

  // Fold a full-precision accumulator into a w-bit result; caller keeps the low w bits of val.
  function automatic red_t reduce_out(input logic signed [CM_MAX_ACC-1:0] acc,
                                      input int unsigned w);
    logic signed [CM_MAX_ACC-1:0] hi, lo;
    red_t r;
    hi    = $signed((CM_MAX_ACC'(1) << (w - 1)) - CM_MAX_ACC'(1));
    lo    = ~hi;
    // Out of range is the same condition as "upper bits not a sign extension".
    r.ovf = (acc > hi) || (acc < lo);
`ifdef CMULT_SAT_EN
    r.val = (acc > hi) ? hi : ((acc < lo) ? lo : acc);
`else
    r.val = acc;
`endif
    return r;
  endfunction

endpackage

// File: rtl/cmult_mac.sv
// Shared signed multiplier with add/subtract accumulate into one of two accumulators.
module cmult_mac
  import cmult_pkg::*;
#(
  parameter int WIDTH = CM_WIDTH,
  parameter int ACC_W = 2*WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    sel_a_im,
  input  logic                    sel_q_im,
  input  logic                    sub,
  input  logic                    acc_im_sel,
  input  logic signed [WIDTH-1:0] re_a,
  input  logic signed [WIDTH-1:0] im_a,
  input  logic signed [WIDTH-1:0] re_q,
  input  logic signed [WIDTH-1:0] im_q,
  output logic signed [ACC_W-1:0] acc_re_nxt,
  output logic signed [ACC_W-1:0] acc_im_nxt
);

  logic signed [WIDTH-1:0]   x, y;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_x, acc_cur, acc_upd;
  logic signed [ACC_W-1:0]   acc_re, acc_im;

  // Operand select, one product, and next accumulator values (exposed so the
  // top can load results on the same edge as the final accumulation).
  always_comb begin
    x       = sel_a_im ? im_a : re_a;
    y       = sel_q_im ? im_q : re_q;
    prod    = (2*WIDTH)'(x) * (2*WIDTH)'(y);
    prod_x  = ACC_W'(prod);
    acc_cur = acc_im_sel ? acc_im : acc_re;
    acc_upd = sub ? (acc_cur - prod_x) : (acc_cur + prod_x);
    acc_re_nxt = acc_re;
    acc_im_nxt = acc_im;
    if (clr) begin
      acc_re_nxt = '0;
      acc_im_nxt = '0;
    end else if (en) begin
      if (acc_im_sel) acc_im_nxt = acc_upd;
      else            acc_re_nxt = acc_upd;
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_re <= '0;
      acc_im <= '0;
    end else begin
      acc_re <= acc_re_nxt;
      acc_im <= acc_im_nxt;
    end
  end

endmodule

// File: rtl/cmult_seq.sv
// Sequential signed complex multiplier: (re_a + j*im_a) * (re_q + j*im_q)
// over four cycles on one shared multiplier, start/busy/done handshake.
// Build option: CMULT_SAT_EN selects saturating results (default wraps).
module cmult_seq
  import cmult_pkg::*;
#(
  parameter int WIDTH = CM_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] re_a,
  input  logic signed [WIDTH-1:0] im_a,
  input  logic signed [WIDTH-1:0] re_q,
  input  logic signed [WIDTH-1:0] im_q,
  output logic signed [WIDTH-1:0] re_res,
  output logic signed [WIDTH-1:0] im_res,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf
);

  localparam int ACC_W = 2*WIDTH + 1;

  state_t state_q, state_d;
  logic signed [WIDTH-1:0] ra_q, ia_q, rq_q, iq_q;
  logic clr, en, sub, sel_a_im, sel_q_im, acc_im_sel, take;
  logic signed [ACC_W-1:0] acc_re_nxt, acc_im_nxt;
  red_t red_re, red_im;

  // Next state and per-phase MAC controls.
  always_comb begin
    state_d    = state_q;
    clr        = 1'b0;
    en         = 1'b0;
    sub        = 1'b0;
    sel_a_im   = 1'b0;
    sel_q_im   = 1'b0;
    acc_im_sel = 1'b0;
    take       = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = P_AC;
        clr     = 1'b1;
        take    = 1'b1;
      end
      P_AC: begin
        en      = 1'b1;
        state_d = P_BD;
      end
      P_BD: begin
        en       = 1'b1;
        sub      = 1'b1;
        sel_a_im = 1'b1;
        sel_q_im = 1'b1;
        state_d  = P_AD;
      end
      P_AD: begin
        en         = 1'b1;
        acc_im_sel = 1'b1;
        sel_q_im   = 1'b1;
        state_d    = P_BC;
      end
      P_BC: begin
        en         = 1'b1;
        acc_im_sel = 1'b1;
        sel_a_im   = 1'b1;
        state_d    = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand capture at start; later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra_q <= '0;
      ia_q <= '0;
      rq_q <= '0;
      iq_q <= '0;
    end else if (take) begin
      ra_q <= re_a;
      ia_q <= im_a;
      rq_q <= re_q;
      iq_q <= im_q;
    end
  end

  cmult_mac #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_mac (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .en         (en),
    .sel_a_im   (sel_a_im),
    .sel_q_im   (sel_q_im),
    .sub        (sub),
    .acc_im_sel (acc_im_sel),
    .re_a       (ra_q),
    .im_a       (ia_q),
    .re_q       (rq_q),
    .im_q       (iq_q),
    .acc_re_nxt (acc_re_nxt),
    .acc_im_nxt (acc_im_nxt)
  );

  // Output reduction of the final accumulator values.
  always_comb begin
    red_re = reduce_out(CM_MAX_ACC'(acc_re_nxt), WIDTH);
    red_im = reduce_out(CM_MAX_ACC'(acc_im_nxt), WIDTH);
  end

  // Results and ovf load only on the P_BC -> DONE edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      re_res <= '0;
      im_res <= '0;
      ovf    <= 1'b0;
    end else if (state_q == P_BC) begin
      re_res <= WIDTH'(red_re.val);
      im_res <= WIDTH'(red_im.val);
      ovf    <= red_re.ovf | red_im.ovf;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
